// File: rtl/rob_commit.sv
// 16-entry circular reorder buffer: in-order allocate, out-of-order write-back,
// in-order retire with a registered regfile write and a flush on a taken jump.
module rob_commit (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        alloc_en,
    input  logic [4:0]  alloc_rd,
    input  logic [31:0] alloc_pc,
    output logic [3:0]  alloc_tag,
    output logic        rob_full,
    input  logic        wb_en,
    input  logic [3:0]  wb_pos_in_rob,
    input  logic [31:0] wb_data,
    input  logic [31:0] pc_to_jump,
    input  logic [3:0]  query_tag,
    output logic        query_ready,
    output logic [31:0] query_data,
    output logic        commit_en,
    output logic [4:0]  commit_rd,
    output logic [31:0] commit_data,
    output logic [3:0]  commit_tag,
    output logic        jump_en,
    output logic [31:0] jump_pc
);

    logic [15:0] valid;
    logic [15:0] ready;
    logic [4:0]  rd_q     [16];
    logic [31:0] pc_q     [16];
    logic [31:0] data_q   [16];
    logic [31:0] target_q [16];

    logic [3:0] head;
    logic [3:0] tail;
    logic [4:0] count;

    logic do_retire;
    logic do_flush;
    logic do_alloc;

    assign alloc_tag = tail;
    assign rob_full  = (count == 5'd16);

    // Readiness is the registered bit, so an entry written back this cycle
    // can only retire on the following edge.
    assign do_retire = valid[head] & ready[head];
    assign do_flush  = do_retire & (target_q[head] != 32'd0);
    assign do_alloc  = alloc_en & ~rob_full;

    always_comb begin
        query_ready = 1'b0;
        query_data  = 32'd0;
        if (valid[query_tag] && ready[query_tag]) begin
            query_ready = 1'b1;
            query_data  = data_q[query_tag];
        end else if (wb_en && (wb_pos_in_rob == query_tag)) begin
            query_ready = 1'b1;
            query_data  = wb_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid       <= 16'd0;
            ready       <= 16'd0;
            head        <= 4'd0;
            tail        <= 4'd0;
            count       <= 5'd0;
            commit_en   <= 1'b0;
            commit_rd   <= 5'd0;
            commit_data <= 32'd0;
            commit_tag  <= 4'd0;
            jump_en     <= 1'b0;
            jump_pc     <= 32'd0;
        end else if (!rdy_in) begin
            commit_en <= 1'b0;
            jump_en   <= 1'b0;
        end else begin
            commit_en <= 1'b0;
            jump_en   <= 1'b0;
            if (do_retire) begin
                commit_en   <= 1'b1;
                commit_rd   <= rd_q[head];
                commit_data <= data_q[head];
                commit_tag  <= head;
            end
            if (do_flush) begin
                jump_en <= 1'b1;
                jump_pc <= target_q[head];
                valid   <= 16'd0;
                ready   <= 16'd0;
                head    <= 4'd0;
                tail    <= 4'd0;
                count   <= 5'd0;
            end else begin
                if (wb_en && valid[wb_pos_in_rob]) begin
                    ready[wb_pos_in_rob]    <= 1'b1;
                    data_q[wb_pos_in_rob]   <= wb_data;
                    target_q[wb_pos_in_rob] <= pc_to_jump;
                end
                if (do_retire) begin
                    valid[head] <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + 4'd1;
                end
                // Allocation targets tail, which never aliases head or a
                // written-back entry unless the buffer is full.
                if (do_alloc) begin
                    valid[tail]    <= 1'b1;
                    ready[tail]    <= 1'b0;
                    rd_q[tail]     <= alloc_rd;
                    pc_q[tail]     <= alloc_pc;
                    target_q[tail] <= 32'd0;
                    tail           <= tail + 4'd1;
                end
                count <= count + {4'd0, do_alloc} - {4'd0, do_retire};
            end
        end
    end

endmodule
